// File: rtl/cr_zigzag_serializer_if.sv
// Block-in / coefficient-out bus of the Cr zigzag serializer.
// The slave side is the serializer; the master side is whoever feeds blocks
// and consumes the coefficient stream.
interface cr_zigzag_serializer_if #(
  parameter int COEFF_W = 11,
  parameter int OUT_W   = 12
);
  logic                                     enable;
  logic signed [0:7][0:7][COEFF_W-1:0]      Q;
  logic                                     in_ready;
  logic                                     dc_clear;
  logic                                     out_valid;
  logic                                     out_ready;
  logic signed [OUT_W-1:0]                  out_data;
  logic [5:0]                               out_index;
  logic                                     out_last;
  logic                                     overflow;

  modport slave (
    input  enable, Q, dc_clear, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, overflow
  );

  modport master (
    output enable, Q, dc_clear, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, overflow
  );
endinterface

// File: rtl/cr_zigzag_serializer.sv
// Cr block zigzag serializer: captures quantized 8x8 blocks into a two-entry
// ping-pong buffer and streams them one coefficient per cycle in JPEG zigzag
// order, replacing DC by its difference from the previous block's DC.
module cr_zigzag_serializer #(
  parameter int COEFF_W = 11,
  parameter int OUT_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  cr_zigzag_serializer_if.slave bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  // Zigzag position -> raster index (row*8+col).
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t                  state_reg, state_next;
  logic [5:0]              index_reg, index_next;
  logic [1:0]              count_reg;
  logic                    wr_ptr_reg, rd_ptr_reg;
  logic signed [OUT_W-1:0] pred_reg;
  logic                    overflow_reg;

  logic [COEFF_W-1:0]      buf_mem [2][64];
  logic [COEFF_W-1:0]      q_raster [64];

  logic                    in_ready;
  logic                    capture, drop, handshake, release_blk;
  logic [COEFF_W-1:0]      coef;
  logic signed [OUT_W-1:0] coef_ext, dc_diff;

  // Flatten the row/column input block into raster order.
  for (genvar gi = 0; gi < 64; gi++) begin : g_raster
    assign q_raster[gi] = bus.Q[gi / 8][gi % 8];
  end

  // A buffer slot freed this cycle only becomes writable next cycle.
  assign in_ready    = (count_reg < 2'd2);
  assign capture     = bus.enable && in_ready;
  assign drop        = bus.enable && !in_ready;
  assign handshake   = (state_reg == STREAM) && bus.out_ready;
  assign release_blk = handshake && (index_reg == 6'd63);

  // Current coefficient of the block being streamed, sign-extended.
  assign coef     = buf_mem[rd_ptr_reg][ZZ[index_reg]];
  assign coef_ext = {{(OUT_W - COEFF_W){coef[COEFF_W-1]}}, coef};
  assign dc_diff  = coef_ext - pred_reg;

  // Store an accepted block into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (rst && capture) begin
      for (int i = 0; i < 64; i++) begin
        buf_mem[wr_ptr_reg][i] <= q_raster[i];
      end
    end
  end

  // Buffer bookkeeping: pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (capture)     wr_ptr_reg <= ~wr_ptr_reg;
      if (release_blk) rd_ptr_reg <= ~rd_ptr_reg;
      case ({capture, release_blk})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // DC predictor: clear has priority over loading the emitted block's DC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pred_reg <= '0;
    end else if (bus.dc_clear) begin
      pred_reg <= '0;
    end else if (handshake && (index_reg == 6'd0)) begin
      pred_reg <= coef_ext;
    end
  end

  // FSM state and zigzag position register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      index_reg <= 6'd0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
    end
  end

  // Next state: start on any buffered block, chain straight into the next one.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg != 2'd0) begin
          state_next = STREAM;
          index_next = 6'd0;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (index_reg == 6'd63) begin
            index_next = 6'd0;
            if (count_reg < 2'd2) state_next = IDLE;
          end else begin
            index_next = index_reg + 6'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        index_next = 6'd0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.overflow  = overflow_reg;
  assign bus.out_valid = (state_reg == STREAM);
  assign bus.out_index = index_reg;
  assign bus.out_last  = (state_reg == STREAM) && (index_reg == 6'd63);
  assign bus.out_data  = (state_reg != STREAM) ? '0 :
                         (index_reg == 6'd0)   ? dc_diff : coef_ext;

endmodule

// File: tb/tb_cr_zigzag_serializer.sv
// Bench for cr_zigzag_serializer: a queue-level model of accepted blocks
// predicts every output each cycle; directed tests pin key words by hand.
module tb_cr_zigzag_serializer;
  localparam int COEFF_W = 11;
  localparam int OUT_W   = 12;

  typedef struct { int c[64]; } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cr_zigzag_serializer_if #(.COEFF_W(COEFF_W), .OUT_W(OUT_W)) bus ();

  cr_zigzag_serializer #(.COEFF_W(COEFF_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int zz_tab [64] = '{
    0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
    35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  // model state
  blk_t mq[$];
  blk_t cur_blk;
  bit   m_stream = 1'b0;
  int   m_pos = 0;
  int   m_pred = 0;
  bit   m_ovf = 1'b0;
  int   got[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: blocks held = queue; front block streams one word per accepted cycle.
  always @(posedge clk) begin
    int  pre;
    bit  hs, rel, acc;
    if (!rst) begin
      mq.delete();
      m_stream = 1'b0;
      m_pos    = 0;
      m_pred   = 0;
      m_ovf    = 1'b0;
    end else begin
      pre = mq.size();
      hs  = m_stream && bus.out_ready;
      rel = hs && (m_pos == 63);
      acc = bus.enable && (pre < 2);
      if (bus.dc_clear) m_pred = 0;
      else if (hs && m_pos == 0) m_pred = mq[0].c[0];
      if (bus.enable && pre >= 2) m_ovf = 1'b1;
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(cur_blk);
      if (rel) begin
        m_pos    = 0;
        m_stream = (pre == 2);
      end else if (hs) begin
        m_pos = m_pos + 1;
      end else if (!m_stream && pre > 0) begin
        m_stream = 1'b1;
        m_pos    = 0;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    int exp_data;
    if (checking) begin
      chk("in_ready", int'(bus.in_ready), int'(mq.size() < 2));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("out_valid", int'(bus.out_valid), int'(m_stream));
      if (m_stream) begin
        exp_data = (m_pos == 0) ? (mq[0].c[0] - m_pred) : mq[0].c[zz_tab[m_pos]];
        chk("out_data", int'(bus.out_data), exp_data);
        chk("out_index", int'(bus.out_index), m_pos);
        chk("out_last", int'(bus.out_last), int'(m_pos == 63));
      end else begin
        chk("idle_data", int'(bus.out_data), 0);
        chk("idle_index", int'(bus.out_index), 0);
        chk("idle_last", int'(bus.out_last), 0);
      end
      if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_data));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_blk(input blk_t b);
    cur_blk = b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        bus.Q[r][c] = COEFF_W'(b.c[r*8+c]);
  endtask

  function automatic blk_t mk_const(input int v);
    blk_t b;
    for (int i = 0; i < 64; i++) b.c[i] = v;
    return b;
  endfunction

  function automatic blk_t mk_dc(input int dc);
    blk_t b;
    for (int i = 0; i < 64; i++) b.c[i] = i - 32;
    b.c[0] = dc;
    return b;
  endfunction

  task automatic send(input blk_t b);
    drive_blk(b);
    bus.enable = 1'b1;
    cycle();
    bus.enable = 1'b0;
  endtask

  // Run until the model holds nothing; optional 1,0,0,1 backpressure pattern.
  task automatic wait_idle(input bit bp);
    logic [3:0] pat = 4'b1001;
    int k = 0;
    while (mq.size() != 0 || m_stream) begin
      if (bp) bus.out_ready = pat[k % 4];
      cycle();
      k++;
      if (k > 1000) begin
        n_total++;
        $display("FAIL wait_idle: timeout after %0d cycles", k);
        break;
      end
    end
    bus.out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    blk_t ramp;
    bus.enable    = 1'b0;
    bus.dc_clear  = 1'b0;
    bus.out_ready = 1'b1;
    drive_blk(mk_const(0));
    rst = 1'b0;
    cycle();
    checking = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // Ramp block in raster order -> zigzag table values.
    for (int i = 0; i < 64; i++) ramp.c[i] = i;
    got.delete();
    send(ramp);
    wait_idle(1'b0);
    chk("ramp_count", got.size(), 64);
    if (got.size() == 64) begin
      chk("ramp_w0", got[0], 0);
      chk("ramp_w2", got[2], 8);
      chk("ramp_w5", got[5], 2);
      chk("ramp_w20", got[20], 40);
      chk("ramp_w63", got[63], 63);
    end

    // Back-to-back blocks all-10 then all-(-3).
    got.delete();
    drive_blk(mk_const(10));
    bus.enable = 1'b1;
    cycle();
    drive_blk(mk_const(-3));
    cycle();
    bus.enable = 1'b0;
    @(negedge clk);
    chk("in_ready_full", int'(bus.in_ready), 0);
    #3;
    wait_idle(1'b0);
    chk("b2b_count", got.size(), 128);
    if (got.size() == 128) begin
      chk("blk1_dc", got[0], 10);
      chk("blk1_ac", got[1], 10);
      chk("blk2_dc", got[64], -13);
      chk("blk2_ac", got[65], -3);
    end

    // Clear predictor, then extreme DC values under backpressure.
    bus.dc_clear = 1'b1;
    cycle();
    bus.dc_clear = 1'b0;
    got.delete();
    send(mk_dc(1023));
    send(mk_dc(-1024));
    wait_idle(1'b1);
    chk("ext_count", got.size(), 128);
    if (got.size() == 128) begin
      chk("ext_dc1", got[0], 1023);
      chk("ext_ac1", got[1], -31);
      chk("ext_dc2", got[64], -2047);
    end

    // Overflow on a third block, then reset mid-stream.
    bus.out_ready = 1'b0;
    send(mk_dc(100));
    send(mk_dc(200));
    send(mk_dc(300));
    @(negedge clk);
    chk("overflow_set", int'(bus.overflow), 1);
    #3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b0;
    drive_blk(mk_dc(77));
    bus.enable = 1'b1;
    cycle();
    bus.enable = 1'b0;
    cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    #3;
    got.delete();
    send(mk_dc(5));
    wait_idle(1'b0);
    chk("post_rst_count", got.size(), 64);
    if (got.size() == 64) chk("post_rst_dc", got[0], 5);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cr_zigzag_serializer.md
Name: cr_zigzag_serializer

Overview:
Downstream neighbour of the Cr quantizer. It captures each quantized 8x8 Cr block, which arrives in parallel on the quantizer's one-cycle out_enable pulse. It then streams the 64 coefficients one per cycle in JPEG zigzag order over a valid/ready handshake toward the run-length/Huffman stage. The DC coefficient is replaced by its difference from the previous block's DC.

Parameters:
- COEFF_W, 11, width of signed quantized input coefficients.
- OUT_W, 12, width of signed output word (COEFF_W+1 so the DC difference cannot overflow).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising edge resets).
- enable  input  1  one-cycle pulse; Q holds a valid block this cycle.
- Q  input  signed [COEFF_W-1:0] [0:7][0:7]  quantized block, Q[row][col].
- in_ready  output  1  high when a block buffer is free.
- dc_clear  input  1  clears the DC predictor to 0 (restart interval).
- out_valid  output  1  out_data/out_index/out_last valid.
- out_ready  input  1  consumer accepts the word when out_valid&&out_ready.
- out_data  output  signed [OUT_W-1:0]  coefficient, sign-extended; DC difference at index 0.
- out_index  output  6  zigzag position 0..63 of the current word.
- out_last  output  1  high with out_index==63.
- overflow  output  1  sticky; a block arrived while in_ready==0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0, DC predictor=0, both buffers empty, write/read pointers=0.
- Storage: two-entry ping-pong block buffer plus an occupancy count of 0..2.
- in_ready = (count<2). It is computed from registered state only. A buffer freed in a cycle is usable from the next cycle; there is no same-cycle bypass.
- Capture: enable && in_ready writes Q into the buffer at wr_ptr, toggles wr_ptr and increments count.
- Dropped block: enable && !in_ready drops the block, sets overflow, and leaves buffer contents unchanged. overflow clears only on reset.
- FSM has two states, IDLE and STREAM.
  - IDLE: out_valid=0. count>0 moves to STREAM with index=0.
  - STREAM: out_valid=1; out_index holds the current position.
  - On handshake with index<63: index increments.
  - On handshake with index==63: the buffer is freed, rd_ptr toggles and count decrements. If another block is buffered, the FSM stays in STREAM with index=0 (no bubble); otherwise it returns to IDLE.
  - out_valid deasserts only in IDLE. Outputs hold stable while out_valid && !out_ready.
- Latency: enable at edge N into an empty block gives out_valid=1 with index 0 after edge N+1. 64 words take a minimum of 64 cycles with out_ready held at 1.
- Simultaneous capture and release in one cycle: the count is unchanged, and both pointer updates apply.
- Zigzag map (position -> raster row*8+col) is the standard JPEG table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- DC handling:
  - At index 0, out_data = sext(Q[0][0]) - pred, in full OUT_W width.
  - pred <= Q[0][0] on the index-0 handshake.
  - Range is -2047..2047, so there is no wrap.
- AC handling: positions 1..63 output sext(coefficient) unchanged.
- dc_clear:
  - Sets pred=0 at the next edge.
  - If it coincides with an index-0 handshake, clear wins (pred=0).
  - Applied while out_valid is high at index 0, out_data recomputes against 0 from the next cycle.
- Reset mid-operation: rst==0 returns every state to its reset value. Buffered blocks are discarded and enable is ignored during reset.

Test Plan:
- Ramp block Q[r][c]=r*8+c, out_ready=1, pred=0 -> 64 consecutive words with out_data equal to the zigzag table value (0,1,8,16,9,...,63), out_last only at index 63, then out_valid=0.
- Two blocks: all-10, then all-(-3) -> block1 DC word 10, block2 DC word -13, AC words unchanged.
- Extreme DC: block DC=1023, then DC=-1024 -> DC words 1023 and -2047, with no wrap.
- Back-to-back blocks at edges N and N+1, out_ready=1 -> 128 contiguous valid words with no bubble. in_ready goes low after the second capture and returns high after word 63 of the first block.
- Backpressure: out_ready toggled 1,0,0,1 -> out_data and out_index held during the stall; no word lost or duplicated.
- Third enable while two blocks are buffered -> overflow=1 and the third block is dropped. Then rst=0 mid-stream -> all outputs and overflow reach their reset values; the next block's DC equals its raw DC value.
